param_seq_detector: RTL and testbench

PARAM_SEQ_DETECTOR -- requirements
Module: param_seq_detector

---
 rtl/param_seq_detector_if.sv | 31 +++
 rtl/param_seq_detector.sv | 124 ++++++++++++
 tb/tb_param_seq_detector.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/param_seq_detector_if.sv
// Signal bundle for param_seq_detector.
//   M          : mode select, 1 = overlapping matches, 0 = non-overlapping
//   X          : raw serial data bit (asynchronous)
//   step       : raw push-button step request (asynchronous, bouncy)
//   Z          : registered match flag
//   Q          : number of valid history bits, saturating at PAT_LEN
//   step_pulse : one-cycle strobe for each accepted step
//   match_cnt  : saturating count of matches since reset
// master drives the raw inputs; slave is the detector.
interface param_seq_detector_if #(
    parameter int unsigned PAT_LEN = 6,
    parameter int unsigned CNT_W   = 8
);
    logic                             M;
    logic                             X;
    logic                             step;
    logic                             Z;
    logic [$clog2(PAT_LEN+1)-1:0]     Q;
    logic                             step_pulse;
    logic [CNT_W-1:0]                 match_cnt;

    modport master (
        output M, X, step,
        input  Z, Q, step_pulse, match_cnt
    );

    modport slave (
        input  M, X, step,
        output Z, Q, step_pulse, match_cnt
    );
endinterface

// File: rtl/param_seq_detector.sv
// Debounced, step-clocked serial pattern detector.
// A push-button step is synchronized, debounced on a divided sample tick and
// turned into a one-cycle step_pulse enable. Each step shifts the synchronized
// X bit into a history register; when PAT_LEN valid bits equal PATTERN, Z is
// set for that step and match_cnt advances (saturating).
// Ports:
//   clk   : system clock, all state on its rising edge
//   reset : asynchronous active-low reset
//   sd    : param_seq_detector_if slave (M, X, step in; Z, Q, step_pulse, match_cnt out)
module param_seq_detector #(
    parameter int unsigned         PAT_LEN    = 6,
    parameter logic [PAT_LEN-1:0]  PATTERN    = PAT_LEN'(6'b101101),
    parameter int unsigned         TICK_DIV   = 500000,
    parameter int unsigned         DB_SAMPLES = 4,
    parameter int unsigned         CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    param_seq_detector_if.slave  sd
);

    localparam int unsigned     QW       = $clog2(PAT_LEN + 1);
    localparam int unsigned     TW       = $clog2(TICK_DIV);
    localparam logic [QW-1:0]   QMax     = QW'(PAT_LEN);
    localparam logic [TW-1:0]   TickLast = TW'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CntMax  = '1;

    // Synchronizers
    logic x_meta_q, x_sync_q;
    logic step_meta_q, step_sync_q;

    // Debounce
    logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
    logic                  tick;
    logic [DB_SAMPLES-1:0] samp_q, samp_d;
    logic                  level_q, level_d;
    logic                  pulse_q, pulse_d;

    // Detector
    logic [PAT_LEN-1:0]    hist_q, hist_d, hist_shift;
    logic [QW-1:0]         q_q, q_d, q_inc;
    logic                  z_q, z_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  match;

    always_comb begin
        tick       = (tick_cnt_q == TickLast);
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

        samp_d  = samp_q;
        level_d = level_q;
        if (tick) begin
            samp_d = {samp_q[DB_SAMPLES-2:0], step_sync_q};
            // Level changes only on unanimous samples; mixed samples hold it.
            if (&samp_d) begin
                level_d = 1'b1;
            end else if (~|samp_d) begin
                level_d = 1'b0;
            end
        end
        pulse_d = level_d & ~level_q;
    end

    always_comb begin
        hist_shift = {hist_q[PAT_LEN-2:0], x_sync_q};
        q_inc      = (q_q == QMax) ? q_q : q_q + 1'b1;
        match      = pulse_q && (q_inc == QMax) && (hist_shift == PATTERN);

        hist_d = hist_q;
        q_d    = q_q;
        z_d    = z_q;
        cnt_d  = cnt_q;
        if (pulse_q) begin
            hist_d = hist_shift;
            q_d    = q_inc;
            z_d    = match;
            if (match) begin
                if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // Non-overlapping: the next match needs PAT_LEN fresh bits.
                if (!sd.M) begin
                    q_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_meta_q    <= 1'b0;
            x_sync_q    <= 1'b0;
            step_meta_q <= 1'b0;
            step_sync_q <= 1'b0;
            tick_cnt_q  <= '0;
            samp_q      <= '0;
            level_q     <= 1'b0;
            pulse_q     <= 1'b0;
            hist_q      <= '0;
            q_q         <= '0;
            z_q         <= 1'b0;
            cnt_q       <= '0;
        end else begin
            x_meta_q    <= sd.X;
            x_sync_q    <= x_meta_q;
            step_meta_q <= sd.step;
            step_sync_q <= step_meta_q;
            tick_cnt_q  <= tick_cnt_d;
            samp_q      <= samp_d;
            level_q     <= level_d;
            pulse_q     <= pulse_d;
            hist_q      <= hist_d;
            q_q         <= q_d;
            z_q         <= z_d;
            cnt_q       <= cnt_d;
        end
    end

    assign sd.Z          = z_q;
    assign sd.Q          = q_q;
    assign sd.step_pulse = pulse_q;
    assign sd.match_cnt  = cnt_q;

endmodule

// File: tb/tb_param_seq_detector.sv
// Scoreboard bench: two detectors (CNT_W=8 and CNT_W=2) share one stimulus.
// Each driven step pushes the reference model's expected Z/Q/counts; each
// observed step_pulse pops and compares them in the following cycle.
module tb_param_seq_detector;

    typedef struct {
        int z;
        int q;
        int cnt;
        int cnt_s;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    param_seq_detector_if #(.PAT_LEN(6), .CNT_W(8)) bus ();
    param_seq_detector_if #(.PAT_LEN(6), .CNT_W(2)) bus_s ();

    param_seq_detector #(
        .PAT_LEN    (6),
        .PATTERN    (6'b101101),
        .TICK_DIV   (4),
        .DB_SAMPLES (3),
        .CNT_W      (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sd    (bus)
    );

    param_seq_detector #(
        .PAT_LEN    (6),
        .PATTERN    (6'b101101),
        .TICK_DIV   (4),
        .DB_SAMPLES (3),
        .CNT_W      (2)
    ) dut_sat (
        .clk   (clk),
        .reset (reset),
        .sd    (bus_s)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_pulses = 0;
    int   n_pushed = 0;
    exp_t sb[$];

    // Reference model state
    logic [5:0] m_hist  = '0;
    int         m_q     = 0;
    int         m_cnt   = 0;
    int         m_cnt_s = 0;
    logic       cur_m   = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic set_in(input logic m, input logic x, input logic st);
        bus.M      = m;
        bus.X      = x;
        bus.step   = st;
        bus_s.M    = m;
        bus_s.X    = x;
        bus_s.step = st;
    endtask

    task automatic model_step(input logic x);
        exp_t e;
        logic hit;
        m_hist = {m_hist[4:0], x};
        if (m_q < 6) m_q++;
        hit = (m_q == 6) && (m_hist == 6'b101101);
        if (hit) begin
            if (m_cnt < 255) m_cnt++;
            if (m_cnt_s < 3) m_cnt_s++;
            if (!cur_m) m_q = 0;
        end
        e.z     = hit ? 1 : 0;
        e.q     = m_q;
        e.cnt   = m_cnt;
        e.cnt_s = m_cnt_s;
        sb.push_back(e);
        n_pushed++;
    endtask

    task automatic model_reset();
        m_hist  = '0;
        m_q     = 0;
        m_cnt   = 0;
        m_cnt_s = 0;
    endtask

    task automatic do_step(input logic x);
        set_in(cur_m, x, 1'b0);
        repeat (4) @(negedge clk);
        model_step(x);
        set_in(cur_m, x, 1'b1);
        repeat (40) @(negedge clk);
        set_in(cur_m, x, 1'b0);
        repeat (40) @(negedge clk);
    endtask

    // Bits sent MSB first
    task automatic do_stream(input logic [31:0] bits, input int len);
        logic [31:0] b;
        b = bits;
        for (int i = len - 1; i >= 0; i--) begin
            do_step(b[i]);
        end
    endtask

    // Asynchronous assertion between edges; outputs must clear without a clock edge.
    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("rst_Z", 32'(bus.Z), 0);
        check("rst_Q", 32'(bus.Q), 0);
        check("rst_cnt", 32'(bus.match_cnt), 0);
        check("rst_pulse", 32'(bus.step_pulse), 0);
        check("rst_cnt_sat", 32'(bus_s.match_cnt), 0);
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Monitor: Z/Q/counts are compared in the cycle after each step_pulse.
    initial begin
        logic pend;
        exp_t e;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    pend = 1'b0;
                    if (sb.size() == 0) begin
                        check("unexpected_pulse", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("Z", 32'(bus.Z), e.z);
                        check("Q", 32'(bus.Q), e.q);
                        check("match_cnt", 32'(bus.match_cnt), e.cnt);
                        check("Z_sat", 32'(bus_s.Z), e.z);
                        check("match_cnt_sat", 32'(bus_s.match_cnt), e.cnt_s);
                    end
                end
                if (bus.step_pulse) begin
                    pend = 1'b1;
                    n_pulses++;
                end
            end
        end
    end

    initial begin
        int p0;
        cur_m = 1'b0;
        set_in(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        check("init_Z", 32'(bus.Z), 0);
        check("init_Q", 32'(bus.Q), 0);
        check("init_cnt", 32'(bus.match_cnt), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Overlapping mode: matches after steps 6 and 9
        cur_m = 1'b1;
        do_stream(32'b101101101, 9);
        check("ovl_cnt_end", 32'(bus.match_cnt), 2);

        // Non-overlapping mode: one match, Q=3 after step 9
        do_reset();
        cur_m = 1'b0;
        do_stream(32'b101101101, 9);
        check("novl_cnt_end", 32'(bus.match_cnt), 1);
        check("novl_Q_end", 32'(bus.Q), 3);

        // Bouncing press then steady hold: one accepted step
        p0 = n_pulses;
        set_in(cur_m, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        model_step(1'b1);
        for (int i = 0; i < 20; i++) begin
            set_in(cur_m, 1'b1, i[0] ? 1'b0 : 1'b1);
            @(negedge clk);
        end
        set_in(cur_m, 1'b1, 1'b1);
        repeat (40) @(negedge clk);
        set_in(cur_m, 1'b1, 1'b0);
        repeat (40) @(negedge clk);
        check("bounce_pulses", 32'(n_pulses - p0), 1);

        // One-tick-wide glitch must be rejected
        p0 = n_pulses;
        set_in(cur_m, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        set_in(cur_m, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        check("glitch_pulses", 32'(n_pulses - p0), 0);

        // Reset mid-pattern discards history
        cur_m = 1'b1;
        do_stream(32'b1011, 4);
        do_reset();
        do_stream(32'b101101, 6);
        check("post_rst_Z", 32'(bus.Z), 1);

        // Saturation: 6 overlapping matches, CNT_W=2 stops at 3
        do_reset();
        cur_m = 1'b1;
        do_stream(32'b101101101101101101101, 21);
        check("sat_cnt8", 32'(bus.match_cnt), 6);
        check("sat_cnt2", 32'(bus_s.match_cnt), 3);

        repeat (5) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 0);
        check("pulse_total", 32'(n_pulses), 32'(n_pushed));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
